// File: rtl/division.sv
// Signed RISC-V style DIV/REM unit: a restoring divider that works on operand magnitudes,
// produces one quotient bit per cycle, then applies sign correction.
module division #(
  parameter int length = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [length-1:0] oper_a,
  input  logic [length-1:0] oper_b,
  input  logic              fuct3,
  input  logic              enable_div,
  output logic [length-1:0] div_o,
  output logic              divided_by_zero,
  output logic              div_finish
);

  localparam int CW = $clog2(length + 1);
  localparam logic [CW-1:0] LAST = CW'(length);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            r_state, w_next;
  logic [length-1:0] r_dividend, r_dmag, r_quo, r_rem;
  logic [CW-1:0]     r_count;
  logic              r_sel, r_zero, r_negQ, r_negR;

  logic [length-1:0] w_aMag, w_bMag, w_quoRes, w_remRes;
  logic [length:0]   w_shift, w_diff;
  logic              w_calcDone;

  // Two's-complement negation maps -2^(length-1) onto itself, which is exactly its unsigned magnitude.
  assign w_aMag = oper_a[length-1] ? (~oper_a + 1'b1) : oper_a;
  assign w_bMag = oper_b[length-1] ? (~oper_b + 1'b1) : oper_b;

  assign w_shift    = {r_rem, r_quo[length-1]};
  assign w_diff     = w_shift - {1'b0, r_dmag};
  assign w_calcDone = r_zero || (r_count == LAST);

  assign w_quoRes = r_negQ ? (~r_quo + 1'b1) : r_quo;
  assign w_remRes = r_negR ? (~r_rem + 1'b1) : r_rem;

  assign div_finish = (r_state == DONE);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (enable_div) w_next = CALC;
      CALC:    if (w_calcDone) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // A zero divisor is finalised on the first CALC cycle, so its result lands one edge after capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dividend      <= '0;
      r_dmag          <= '0;
      r_quo           <= '0;
      r_rem           <= '0;
      r_count         <= '0;
      r_sel           <= 1'b0;
      r_zero          <= 1'b0;
      r_negQ          <= 1'b0;
      r_negR          <= 1'b0;
      div_o           <= '0;
      divided_by_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (enable_div) begin
            r_dividend <= oper_a;
            r_dmag     <= w_bMag;
            r_quo      <= w_aMag;
            r_rem      <= '0;
            r_count    <= '0;
            r_sel      <= fuct3;
            r_zero     <= (oper_b == '0);
            r_negQ     <= oper_a[length-1] ^ oper_b[length-1];
            r_negR     <= oper_a[length-1];
          end
        end
        CALC: begin
          if (w_calcDone) begin
            if (r_zero) div_o <= r_sel ? '1 : r_dividend;
            else        div_o <= r_sel ? w_quoRes : w_remRes;
            divided_by_zero <= r_zero;
          end else begin
            if (!w_diff[length]) begin
              r_rem <= w_diff[length-1:0];
              r_quo <= {r_quo[length-2:0], 1'b1};
            end else begin
              r_rem <= w_shift[length-1:0];
              r_quo <= {r_quo[length-2:0], 1'b0};
            end
            r_count <= r_count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_division.sv
// Directed self-checking bench for the division block: arithmetic, latency, divide-by-zero,
// overflow, input capture, back-to-back operation and reset behaviour.
module tb_division;

  logic        clk;
  logic        rst;
  logic [31:0] oper_a;
  logic [31:0] oper_b;
  logic        fuct3;
  logic        enable_div;
  logic [31:0] div_o;
  logic        divided_by_zero;
  logic        div_finish;

  int vectors;
  int miscompares;

  division #(.length(32)) dut (
    .clk(clk),
    .rst(rst),
    .oper_a(oper_a),
    .oper_b(oper_b),
    .fuct3(fuct3),
    .enable_div(enable_div),
    .div_o(div_o),
    .divided_by_zero(divided_by_zero),
    .div_finish(div_finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one operation; lat is the number of edges from capture to the first div_finish (-1 on timeout).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic f,
                        output logic [31:0] res, output logic dz, output int lat);
    @(posedge clk); #1;
    oper_a = a; oper_b = b; fuct3 = f; enable_div = 1'b1;
    @(posedge clk); #1;
    enable_div = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (div_finish) begin
        lat = k;
        break;
      end
    end
    res = div_o;
    dz  = divided_by_zero;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; enable_div = 1'b1; oper_a = 32'd5; oper_b = 32'd0; fuct3 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (div_o !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_div_o got %h want %h", div_o, 32'd0); end
    vectors++;
    if (divided_by_zero !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_dz got %b want 0", divided_by_zero); end
    vectors++;
    if (div_finish !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_finish got %b want 0", div_finish); end
    rst = 1'b0; enable_div = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      vectors++;
      if (div_finish !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_priority finish got %b want 0", div_finish); end
    end
  endtask

  task automatic test_unsigned;
    logic [31:0] ta [6] = '{32'd7, 32'd7, 32'd3025, 32'd3025, 32'd18, 32'd18};
    logic [31:0] tb [6] = '{32'd3, 32'd3, 32'd12,   32'd12,   32'd6,  32'd6};
    logic        tf [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] te [6] = '{32'd2, 32'd1, 32'd252,  32'd1,    32'd3,  32'd0};
    logic [31:0] res;
    logic        dz;
    int          lat;
    for (int i = 0; i < 6; i++) begin
      run_op(ta[i], tb[i], tf[i], res, dz, lat);
      vectors++;
      if (res !== te[i]) begin miscompares++; $display("[TB] FAIL unsigned[%0d] div_o got %h want %h", i, res, te[i]); end
      vectors++;
      if (dz !== 1'b0) begin miscompares++; $display("[TB] FAIL unsigned[%0d] dz got %b want 0", i, dz); end
      vectors++;
      if (lat !== 33) begin miscompares++; $display("[TB] FAIL unsigned[%0d] latency got %0d want 33", i, lat); end
      vectors++;
      if (div_finish !== 1'b0) begin miscompares++; $display("[TB] FAIL unsigned[%0d] finish_width got %b want 0", i, div_finish); end
    end
  endtask

  task automatic test_signed;
    logic [31:0] ta [6] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7, 32'd7, 32'hFFFFFFF9, 32'hFFFFFFF9};
    logic [31:0] tb [6] = '{32'd3, 32'd3, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFD};
    logic        tf [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] te [6] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1, 32'd2, 32'hFFFFFFFF};
    logic [31:0] res;
    logic        dz;
    int          lat;
    for (int i = 0; i < 6; i++) begin
      run_op(ta[i], tb[i], tf[i], res, dz, lat);
      vectors++;
      if (res !== te[i]) begin miscompares++; $display("[TB] FAIL signed[%0d] div_o got %h want %h", i, res, te[i]); end
      vectors++;
      if (lat !== 33) begin miscompares++; $display("[TB] FAIL signed[%0d] latency got %0d want 33", i, lat); end
    end
  endtask

  task automatic test_div_zero;
    logic [31:0] res;
    logic        dz;
    int          lat;
    run_op(32'hFFFFFFF9, 32'd0, 1'b1, res, dz, lat);
    vectors++;
    if (res !== 32'hFFFFFFFF) begin miscompares++; $display("[TB] FAIL divzero_quo div_o got %h want ffffffff", res); end
    vectors++;
    if (dz !== 1'b1) begin miscompares++; $display("[TB] FAIL divzero_quo dz got %b want 1", dz); end
    vectors++;
    if (lat !== 1) begin miscompares++; $display("[TB] FAIL divzero_quo latency got %0d want 1", lat); end
    vectors++;
    if (div_finish !== 1'b0) begin miscompares++; $display("[TB] FAIL divzero finish_width got %b want 0", div_finish); end
    run_op(32'hFFFFFFF9, 32'd0, 1'b0, res, dz, lat);
    vectors++;
    if (res !== 32'hFFFFFFF9) begin miscompares++; $display("[TB] FAIL divzero_rem div_o got %h want fffffff9", res); end
    vectors++;
    if (dz !== 1'b1) begin miscompares++; $display("[TB] FAIL divzero_rem dz got %b want 1", dz); end
    vectors++;
    if (lat !== 1) begin miscompares++; $display("[TB] FAIL divzero_rem latency got %0d want 1", lat); end
  endtask

  task automatic test_overflow;
    logic [31:0] ta [3] = '{32'h80000000, 32'h80000000, 32'h80000000};
    logic [31:0] tb [3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2};
    logic        tf [3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] te [3] = '{32'h80000000, 32'd0, 32'hC0000000};
    logic [31:0] res;
    logic        dz;
    int          lat;
    for (int i = 0; i < 3; i++) begin
      run_op(ta[i], tb[i], tf[i], res, dz, lat);
      vectors++;
      if (res !== te[i]) begin miscompares++; $display("[TB] FAIL overflow[%0d] div_o got %h want %h", i, res, te[i]); end
      vectors++;
      if (dz !== 1'b0) begin miscompares++; $display("[TB] FAIL overflow[%0d] dz got %b want 0", i, dz); end
      vectors++;
      if (lat !== 33) begin miscompares++; $display("[TB] FAIL overflow[%0d] latency got %0d want 33", i, lat); end
    end
  endtask

  task automatic test_midcalc_change;
    int lat;
    @(posedge clk); #1;
    oper_a = 32'd3025; oper_b = 32'd12; fuct3 = 1'b1; enable_div = 1'b1;
    @(posedge clk); #1;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) begin
        oper_a = 32'd99; oper_b = 32'd0; fuct3 = 1'b0; enable_div = 1'b0;
      end
      @(posedge clk); #1;
      if (div_finish) begin
        lat = k;
        break;
      end
    end
    vectors++;
    if (div_o !== 32'd252) begin miscompares++; $display("[TB] FAIL midcalc div_o got %h want %h", div_o, 32'd252); end
    vectors++;
    if (divided_by_zero !== 1'b0) begin miscompares++; $display("[TB] FAIL midcalc dz got %b want 0", divided_by_zero); end
    vectors++;
    if (lat !== 33) begin miscompares++; $display("[TB] FAIL midcalc latency got %0d want 33", lat); end
    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if (div_o !== 32'd252) begin miscompares++; $display("[TB] FAIL hold div_o got %h want %h", div_o, 32'd252); end
  endtask

  task automatic test_back_to_back;
    int fin [$];
    int prev;
    @(posedge clk); #1;
    oper_a = 32'd100; oper_b = 32'd7; fuct3 = 1'b1; enable_div = 1'b1;
    @(posedge clk); #1;
    prev = -10;
    for (int c = 1; c <= 110; c++) begin
      @(posedge clk); #1;
      if (div_finish) begin
        vectors++;
        if (prev == c - 1) begin miscompares++; $display("[TB] FAIL b2b_width finish at %0d and %0d", prev, c); end
        vectors++;
        if (div_o !== 32'd14) begin miscompares++; $display("[TB] FAIL b2b div_o got %h want %h", div_o, 32'd14); end
        fin.push_back(c);
        prev = c;
      end
    end
    vectors++;
    if (fin.size() !== 3) begin miscompares++; $display("[TB] FAIL b2b_count got %0d want 3", fin.size()); end
    else begin
      vectors++;
      if (fin[0] !== 33 || fin[1] !== 68 || fin[2] !== 103)
        begin miscompares++; $display("[TB] FAIL b2b_spacing got %0d,%0d,%0d want 33,68,103", fin[0], fin[1], fin[2]); end
    end
    enable_div = 1'b0; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset_midop;
    logic [31:0] res;
    logic        dz;
    int          lat;
    int          seen;
    run_op(32'd18, 32'd6, 1'b1, res, dz, lat);
    vectors++;
    if (res !== 32'd3) begin miscompares++; $display("[TB] FAIL pre_reset div_o got %h want %h", res, 32'd3); end
    oper_a = 32'd7; oper_b = 32'd3; fuct3 = 1'b1; enable_div = 1'b1;
    @(posedge clk); #1;
    enable_div = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (div_finish) seen++;
      @(posedge clk); #1;
    end
    vectors++;
    if (seen !== 0) begin miscompares++; $display("[TB] FAIL abort finish_count got %0d want 0", seen); end
    vectors++;
    if (div_o !== 32'd0) begin miscompares++; $display("[TB] FAIL abort div_o got %h want 0", div_o); end
    vectors++;
    if (divided_by_zero !== 1'b0) begin miscompares++; $display("[TB] FAIL abort dz got %b want 0", divided_by_zero); end
    run_op(32'hFFFFFFF9, 32'd3, 1'b0, res, dz, lat);
    vectors++;
    if (res !== 32'hFFFFFFFF) begin miscompares++; $display("[TB] FAIL post_reset div_o got %h want ffffffff", res); end
    vectors++;
    if (lat !== 33) begin miscompares++; $display("[TB] FAIL post_reset latency got %0d want 33", lat); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; enable_div = 1'b0; oper_a = '0; oper_b = '0; fuct3 = 1'b0;
    test_reset;
    test_unsigned;
    test_signed;
    test_div_zero;
    test_overflow;
    test_midcalc_change;
    test_back_to_back;
    test_reset_midop;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
